// File: rtl/ahb_pkg.sv
// Shared AHB encodings and field types used by the master-side multiplexor.
package ahb_pkg;

    typedef logic [1:0] htrans_t;
    typedef logic [2:0] hburst_t;
    typedef logic [2:0] hsize_t;

    localparam htrans_t HTRANS_IDLE   = 2'b00;
    localparam htrans_t HTRANS_BUSY   = 2'b01;
    localparam htrans_t HTRANS_NONSEQ = 2'b10;
    localparam htrans_t HTRANS_SEQ    = 2'b11;

    localparam hburst_t HBURST_SINGLE = 3'b000;
    localparam hburst_t HBURST_INCR   = 3'b001;
    localparam hburst_t HBURST_WRAP4  = 3'b010;
    localparam hburst_t HBURST_INCR4  = 3'b011;
    localparam hburst_t HBURST_WRAP8  = 3'b100;
    localparam hburst_t HBURST_INCR8  = 3'b101;
    localparam hburst_t HBURST_WRAP16 = 3'b110;
    localparam hburst_t HBURST_INCR16 = 3'b111;

    localparam hsize_t HSIZE_BYTE  = 3'b000;
    localparam hsize_t HSIZE_HALF  = 3'b001;
    localparam hsize_t HSIZE_WORD  = 3'b010;
    localparam hsize_t HSIZE_DWORD = 3'b011;

endpackage

// File: rtl/ahb_master_mux_pipe_if.sv
// Bus bundle between N AHB masters, the master mux and the downstream slave decoder.
interface ahb_master_mux_pipe_if
    import ahb_pkg::*;
#(
    parameter int MASTERS_NUM = 4,
    parameter int ADDR_WIDTH  = 32,
    parameter int DATA_WIDTH  = 32,
    parameter int SLAVES_NUM  = 4
);
    localparam int MW = $clog2(MASTERS_NUM);
    localparam int SW = $clog2(SLAVES_NUM);

    logic [MASTERS_NUM-1:0]            grant;
    logic                              hready;
    logic [MASTERS_NUM*ADDR_WIDTH-1:0] haddr_m;
    logic [MASTERS_NUM-1:0]            hwrite_m;
    logic [MASTERS_NUM*3-1:0]          hsize_m;
    logic [MASTERS_NUM*3-1:0]          hburst_m;
    logic [MASTERS_NUM*4-1:0]          hprot_m;
    logic [MASTERS_NUM*2-1:0]          htrans_m;
    logic [MASTERS_NUM-1:0]            hlock_m;
    logic [MASTERS_NUM*SW-1:0]         hsel_m;
    logic [MASTERS_NUM*DATA_WIDTH-1:0] hwdata_m;

    logic [ADDR_WIDTH-1:0]             haddr;
    logic                              hwrite;
    hsize_t                            hsize;
    hburst_t                           hburst;
    logic [3:0]                        hprot;
    htrans_t                           htrans;
    logic                              hlock;
    logic [SW-1:0]                     hsel;
    logic [DATA_WIDTH-1:0]             hwdata;
    logic [MW-1:0]                     hmaster;
    logic [MW-1:0]                     hmaster_data;
    logic                              grant_err;

    modport master (
        input  grant, hready, haddr_m, hwrite_m, hsize_m, hburst_m, hprot_m,
               htrans_m, hlock_m, hsel_m, hwdata_m,
        output haddr, hwrite, hsize, hburst, hprot, htrans, hlock, hsel,
               hwdata, hmaster, hmaster_data, grant_err
    );

    modport slave (
        output grant, hready, haddr_m, hwrite_m, hsize_m, hburst_m, hprot_m,
               htrans_m, hlock_m, hsel_m, hwdata_m,
        input  haddr, hwrite, hsize, hburst, hprot, htrans, hlock, hsel,
               hwdata, hmaster, hmaster_data, grant_err
    );

endinterface

// File: rtl/ahb_onehot_enc.sv
// One-hot to binary index encoder; valid only when exactly one bit is set.
module ahb_onehot_enc #(
    parameter int MASTERS_NUM = 4
) (
    input  logic [MASTERS_NUM-1:0]         onehot,
    output logic [$clog2(MASTERS_NUM)-1:0] idx,
    output logic                           valid
);
    localparam int MW = $clog2(MASTERS_NUM);

    // OR of set-bit indices; only meaningful when valid is high.
    always_comb begin
        idx = '0;
        for (int i = 0; i < MASTERS_NUM; i++) begin
            if (onehot[i]) idx = idx | MW'(i);
        end
    end

    assign valid = (onehot != '0) &&
                   ((onehot & (onehot - MASTERS_NUM'(1))) == '0);

endmodule

// File: rtl/ahb_master_mux_pipe.sv
// AHB master-side mux: registered address-phase owner routes address/control,
// a data-phase owner lagging one accepted transfer routes hwdata.
module ahb_master_mux_pipe
    import ahb_pkg::*;
#(
    parameter int MASTERS_NUM    = 4,
    parameter int ADDR_WIDTH     = 32,
    parameter int DATA_WIDTH     = 32,
    parameter int SLAVES_NUM     = 4,
    parameter int DEFAULT_MASTER = 0
) (
    input  logic                  hclk,
    input  logic                  hresetn,
    ahb_master_mux_pipe_if.master bus
);
    localparam int MW = $clog2(MASTERS_NUM);
    localparam int SW = $clog2(SLAVES_NUM);
    localparam logic [MW-1:0] DFLT = MW'(DEFAULT_MASTER);

    logic [MW-1:0] addr_owner;
    logic [MW-1:0] data_owner;
    logic [MW-1:0] grant_idx;
    logic          grant_vld;
    logic          lock_hold;
    logic          dflt_forced;
    logic          grant_err_q;
    htrans_t       owner_trans;

    ahb_onehot_enc #(.MASTERS_NUM(MASTERS_NUM)) u_enc (
        .onehot (bus.grant),
        .idx    (grant_idx),
        .valid  (grant_vld)
    );

    // A locked owner mid-transfer keeps the bus regardless of the arbiter.
    assign owner_trans = bus.htrans_m[int'(addr_owner)*2 +: 2];
    assign lock_hold   = bus.hlock_m[addr_owner] && (owner_trans != HTRANS_IDLE);

    always_ff @(posedge hclk or negedge hresetn) begin
        if (!hresetn) begin
            addr_owner  <= DFLT;
            data_owner  <= DFLT;
            dflt_forced <= 1'b0;
            grant_err_q <= 1'b0;
        end else if (bus.hready) begin
            data_owner <= addr_owner;
            if (lock_hold) begin
                grant_err_q <= 1'b0;
            end else if (grant_vld) begin
                addr_owner  <= grant_idx;
                dflt_forced <= 1'b0;
                grant_err_q <= 1'b0;
            end else begin
                addr_owner  <= DFLT;
                dflt_forced <= 1'b1;
                grant_err_q <= 1'b1;
            end
        end else begin
            grant_err_q <= 1'b0;
        end
    end

    // Fallback ownership must not issue transfers the default master never requested.
    assign bus.haddr        = bus.haddr_m[int'(addr_owner)*ADDR_WIDTH +: ADDR_WIDTH];
    assign bus.hwrite       = bus.hwrite_m[addr_owner];
    assign bus.hsize        = bus.hsize_m[int'(addr_owner)*3 +: 3];
    assign bus.hburst       = bus.hburst_m[int'(addr_owner)*3 +: 3];
    assign bus.hprot        = bus.hprot_m[int'(addr_owner)*4 +: 4];
    assign bus.htrans       = dflt_forced ? HTRANS_IDLE : owner_trans;
    assign bus.hlock        = bus.hlock_m[addr_owner];
    assign bus.hsel         = bus.hsel_m[int'(addr_owner)*SW +: SW];
    assign bus.hwdata       = bus.hwdata_m[int'(data_owner)*DATA_WIDTH +: DATA_WIDTH];
    assign bus.hmaster      = addr_owner;
    assign bus.hmaster_data = data_owner;
    assign bus.grant_err    = grant_err_q;

endmodule

// File: tb/tb_ahb_master_mux_pipe.sv
// Scoreboard bench for ahb_master_mux_pipe with 4-, 8- and 3-master instances.
module tb_ahb_master_mux_pipe;

    logic clk = 1'b0;
    logic hresetn;

    always #5 clk = ~clk;

    ahb_master_mux_pipe_if #(.MASTERS_NUM(4)) b4 ();
    ahb_master_mux_pipe_if #(.MASTERS_NUM(8)) b8 ();
    ahb_master_mux_pipe_if #(.MASTERS_NUM(3)) b3 ();

    ahb_master_mux_pipe #(.MASTERS_NUM(4)) u4 (.hclk(clk), .hresetn(hresetn), .bus(b4.master));
    ahb_master_mux_pipe #(.MASTERS_NUM(8)) u8 (.hclk(clk), .hresetn(hresetn), .bus(b8.master));
    ahb_master_mux_pipe #(.MASTERS_NUM(3)) u3 (.hclk(clk), .hresetn(hresetn), .bus(b3.master));

    typedef struct {
        logic [31:0] hm, hmd, err, addr, wdata, trans, sel, wr;
    } exp_t;

    exp_t sbq[$];
    int   n_chk  = 0;
    int   n_pass = 0;
    int   m_addr, m_data, m_err;
    bit   m_forced;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        if (obs === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h at %0t", tag, obs, exp, $time);
    endtask

    // Model the next owner state from the inputs about to be sampled, then compare after the edge.
    task automatic step4();
        exp_t e;
        bit   lockd;
        if (b4.hready) begin
            lockd  = b4.hlock_m[m_addr] && (b4.htrans_m[m_addr*2 +: 2] != 2'b00);
            m_data = m_addr;
            if (lockd) begin
                m_err = 0;
            end else if ($countones(b4.grant) == 1) begin
                for (int i = 0; i < 4; i++) if (b4.grant[i]) m_addr = i;
                m_forced = 1'b0;
                m_err    = 0;
            end else begin
                m_addr   = 0;
                m_forced = 1'b1;
                m_err    = 1;
            end
        end else begin
            m_err = 0;
        end
        e.hm    = 32'(m_addr);
        e.hmd   = 32'(m_data);
        e.err   = 32'(m_err);
        e.addr  = b4.haddr_m[m_addr*32 +: 32];
        e.wdata = b4.hwdata_m[m_data*32 +: 32];
        e.trans = m_forced ? 32'd0 : 32'(b4.htrans_m[m_addr*2 +: 2]);
        e.sel   = 32'(b4.hsel_m[m_addr*2 +: 2]);
        e.wr    = 32'(b4.hwrite_m[m_addr]);
        sbq.push_back(e);
        @(posedge clk);
        #1;
        e = sbq.pop_front();
        chk("hmaster",      32'(b4.hmaster),      e.hm);
        chk("hmaster_data", 32'(b4.hmaster_data), e.hmd);
        chk("grant_err",    32'(b4.grant_err),    e.err);
        chk("haddr",        b4.haddr,             e.addr);
        chk("hwdata",       b4.hwdata,            e.wdata);
        chk("htrans",       32'(b4.htrans),       e.trans);
        chk("hsel",         32'(b4.hsel),         e.sel);
        chk("hwrite",       32'(b4.hwrite),       e.wr);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
        $fatal(1);
    end

    initial begin
        hresetn = 1'b0;
        b4.hready = 1'b1; b4.grant = 4'b0100;
        b4.hwrite_m = 4'b0101; b4.hsel_m = 8'hE4; b4.htrans_m = 8'hAA; b4.hlock_m = '0;
        b4.hsize_m = '0; b4.hburst_m = '0; b4.hprot_m = '0;
        for (int i = 0; i < 4; i++) begin
            b4.haddr_m[i*32 +: 32]  = 32'h1000_0000 * (i + 1) + 32'h40 * i;
            b4.hwdata_m[i*32 +: 32] = 32'hD000_0000 | i;
        end
        b8.hready = 1'b1; b8.grant = 8'h01; b8.htrans_m = 16'hAAAA; b8.hlock_m = '0;
        b8.hwrite_m = '0; b8.hsel_m = '0; b8.hsize_m = '0; b8.hburst_m = '0; b8.hprot_m = '0;
        for (int i = 0; i < 8; i++) begin
            b8.haddr_m[i*32 +: 32]  = 32'h8000_0000 + 32'h100 * i;
            b8.hwdata_m[i*32 +: 32] = 32'hBEEF_0000 + i;
        end
        b3.hready = 1'b1; b3.grant = 3'b001; b3.htrans_m = 6'b101010; b3.hlock_m = '0;
        b3.hwrite_m = '0; b3.hsel_m = '0; b3.hsize_m = '0; b3.hburst_m = '0; b3.hprot_m = '0;
        for (int i = 0; i < 3; i++) begin
            b3.haddr_m[i*32 +: 32]  = 32'h3000_0000 + 32'h10 * i;
            b3.hwdata_m[i*32 +: 32] = 32'hC0DE_0000 + i;
        end

        // Reset: grant to M2 is ignored, outputs follow the default master
        tick(); tick();
        chk("rst_hmaster",      32'(b4.hmaster),      32'd0);
        chk("rst_hmaster_data", 32'(b4.hmaster_data), 32'd0);
        chk("rst_haddr",        b4.haddr,             32'h1000_0000);
        chk("rst_grant_err",    32'(b4.grant_err),    32'd0);
        hresetn = 1'b1;
        m_addr = 0; m_data = 0; m_err = 0; m_forced = 1'b0;

        // Handover M0 -> M1
        b4.grant = 4'b0001; step4();
        b4.grant = 4'b0010; step4(); step4();

        // Stall: grant to M3 ignored until hready returns
        b4.grant = 4'b1000; b4.hready = 1'b0;
        step4(); step4(); step4();
        b4.hready = 1'b1; step4(); step4();

        // Invalid grants fall back to default with forced IDLE
        b4.grant = 4'b0110; step4();
        b4.grant = 4'b0000; step4();
        b4.grant = 4'b0001; step4();
        b4.grant = 4'b0110; step4();
        b4.grant = 4'b0100; step4();

        // Lock hold on M2
        b4.hlock_m = 4'b0100;
        b4.grant = 4'b0010; step4(); step4();
        b4.grant = 4'b0000; step4();
        b4.hready = 1'b0; step4();
        b4.hready = 1'b1; b4.htrans_m[5:4] = 2'b00; b4.grant = 4'b0010; step4();
        b4.hlock_m = '0; b4.htrans_m = 8'hAA; step4();

        // Asynchronous reset between edges
        #3 hresetn = 1'b0;
        #1;
        chk("arst_hmaster",      32'(b4.hmaster),      32'd0);
        chk("arst_hmaster_data", 32'(b4.hmaster_data), 32'd0);
        chk("arst_grant_err",    32'(b4.grant_err),    32'd0);
        chk("arst_hwdata",       b4.hwdata,            32'hD000_0000);
        @(negedge clk);
        hresetn = 1'b1;
        m_addr = 0; m_data = 0; m_err = 0; m_forced = 1'b0;
        b4.grant = 4'b0010; step4(); step4();

        // Random traffic against the model
        for (int k = 0; k < 40; k++) begin
            int r;
            b4.hready = ($urandom_range(0, 3) != 0);
            r = $urandom_range(0, 5);
            if (r < 4) b4.grant = 4'(1 << r);
            else       b4.grant = 4'($urandom_range(0, 15));
            b4.hlock_m  = 4'($urandom);
            b4.htrans_m = 8'($urandom);
            step4();
        end

        // 8-master regression: handover then invalid grant
        b8.grant = 8'h80; tick();
        chk("m8_hmaster",      32'(b8.hmaster),      32'd7);
        chk("m8_hmaster_data", 32'(b8.hmaster_data), 32'd0);
        tick();
        chk("m8_hmaster_data2", 32'(b8.hmaster_data), 32'd7);
        chk("m8_hwdata",        b8.hwdata,            32'hBEEF_0007);
        chk("m8_haddr",         b8.haddr,             32'h8000_0700);
        b8.grant = 8'h30; tick();
        chk("m8_inv_hmaster", 32'(b8.hmaster),   32'd0);
        chk("m8_inv_htrans",  32'(b8.htrans),    32'd0);
        chk("m8_inv_err",     32'(b8.grant_err), 32'd1);
        b8.grant = 8'h00; tick();
        chk("m8_zero_err",    32'(b8.grant_err), 32'd1);
        b8.grant = 8'h04; tick();
        chk("m8_rec_err",     32'(b8.grant_err), 32'd0);
        chk("m8_rec_hmaster", 32'(b8.hmaster),   32'd2);
        chk("m8_rec_htrans",  32'(b8.htrans),    32'd2);

        // 3-master regression
        b3.grant = 3'b100; tick();
        chk("m3_hmaster", 32'(b3.hmaster), 32'd2);
        tick();
        chk("m3_hmaster_data", 32'(b3.hmaster_data), 32'd2);
        chk("m3_hwdata",       b3.hwdata,            32'hC0DE_0002);
        b3.grant = 3'b011; tick();
        chk("m3_inv_hmaster", 32'(b3.hmaster),   32'd0);
        chk("m3_inv_htrans",  32'(b3.htrans),    32'd0);
        chk("m3_inv_err",     32'(b3.grant_err), 32'd1);
        b3.grant = 3'b010; tick();
        chk("m3_rec_err",     32'(b3.grant_err), 32'd0);
        chk("m3_rec_hmaster", 32'(b3.hmaster),   32'd1);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
